// File: rtl/motor_pkg.sv
// Shared types and constants for the motor sampling loop.
package motor_pkg;

    localparam int unsigned DATA_W_DEF = 16;

    // Sequencer state encoding.
    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_REQ  = 3'd1,
        ST_WAIT = 3'd2,
        ST_CALC = 3'd3,
        ST_OUT  = 3'd4
    } state_t;

    // Saturation limits of a DATA_W_DEF-wide two's-complement error.
    localparam logic [DATA_W_DEF-1:0] ERR_MAX_DEF = {1'b0, {(DATA_W_DEF-1){1'b1}}};
    localparam logic [DATA_W_DEF-1:0] ERR_MIN_DEF = {1'b1, {(DATA_W_DEF-1){1'b0}}};

endpackage

// File: rtl/motor_err_sat.sv
// Combinational saturated subtract: err_c = clamp(target - pos).
module motor_err_sat
    import motor_pkg::*;
#(
    parameter int unsigned DATA_W = DATA_W_DEF
) (
    input  logic [DATA_W-1:0] target,
    input  logic [DATA_W-1:0] pos,
    output logic [DATA_W-1:0] err_c
);

    localparam logic [DATA_W-1:0] SAT_MAX = {1'b0, {(DATA_W-1){1'b1}}};
    localparam logic [DATA_W-1:0] SAT_MIN = {1'b1, {(DATA_W-1){1'b0}}};

    logic [DATA_W:0] diff;

    // One extra bit holds the exact difference; top two bits disagreeing means overflow.
    always_comb begin
        diff  = {target[DATA_W-1], target} - {pos[DATA_W-1], pos};
        err_c = diff[DATA_W-1:0];
        if (diff[DATA_W] != diff[DATA_W-1]) begin
            err_c = diff[DATA_W] ? SAT_MIN : SAT_MAX;
        end
    end

endmodule

// File: rtl/motor_sample_sequencer.sv
// Trigger-driven ADC sampling and position-error hand-off to the PID stage.
// Build option: MOTOR_SAMPLE_AVG_EN averages two conversions per trigger.
module motor_sample_sequencer
    import motor_pkg::*;
#(
    parameter int unsigned DATA_W      = DATA_W_DEF,
    parameter int unsigned TIMEOUT_CYC = 5000,
    parameter int unsigned MISS_W      = 16
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              motor_bias_vol_en_i,
    input  logic              motor_trigger_i,
    input  logic [DATA_W-1:0] motor_target_i,
    output logic              adc_conv_req_o,
    input  logic              adc_data_vld_i,
    input  logic [DATA_W-1:0] adc_data_i,
    output logic              err_vld_o,
    input  logic              err_rdy_i,
    output logic [DATA_W-1:0] err_data_o,
    output logic [DATA_W-1:0] err_pos_o,
    output logic              adc_timeout_o,
    output logic [MISS_W-1:0] miss_cnt_o,
    output logic              busy_o
);

    localparam int unsigned     CNT_W    = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);

    state_t            state_q, state_d;
    logic              trig_d_q;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [DATA_W-1:0] pos_q, pos_d;
    logic              req_q, req_d;
    logic              vld_q, vld_d;
    logic [DATA_W-1:0] err_q, err_d;
    logic [DATA_W-1:0] epos_q, epos_d;
    logic              tmo_q, tmo_d;
    logic [MISS_W-1:0] miss_q, miss_d;
    logic              busy_q, busy_d;
    logic              edge_c;
    logic [DATA_W-1:0] sat_c;
    logic [DATA_W-1:0] sample_c;

    assign edge_c = motor_trigger_i & ~trig_d_q;

    motor_err_sat #(.DATA_W(DATA_W)) u_err_sat (
        .target (motor_target_i),
        .pos    (pos_q),
        .err_c  (sat_c)
    );

`ifdef MOTOR_SAMPLE_AVG_EN
    logic            second_q, second_d;
    logic [DATA_W:0] avg_sum_c;

    // Floor average of the first and second samples via arithmetic shift.
    assign avg_sum_c = {pos_q[DATA_W-1], pos_q} + {adc_data_i[DATA_W-1], adc_data_i};
    assign sample_c  = avg_sum_c[DATA_W:1];
`else
    assign sample_c  = adc_data_i;
`endif

    // Next-state and registered-output computation.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        pos_d    = pos_q;
        req_d    = 1'b0;
        vld_d    = vld_q;
        err_d    = err_q;
        epos_d   = epos_q;
        tmo_d    = 1'b0;
        miss_d   = miss_q;
`ifdef MOTOR_SAMPLE_AVG_EN
        second_d = second_q;
`endif
        if (motor_bias_vol_en_i) begin
            state_d  = ST_IDLE;
            vld_d    = 1'b0;
`ifdef MOTOR_SAMPLE_AVG_EN
            second_d = 1'b0;
`endif
        end else begin
            if (edge_c && (state_q != ST_IDLE) && (miss_q != {MISS_W{1'b1}})) begin
                miss_d = miss_q + MISS_W'(1);
            end
            case (state_q)
                ST_IDLE: begin
                    if (edge_c) begin
                        state_d = ST_REQ;
                        req_d   = 1'b1;
                    end
                end
                ST_REQ: begin
                    cnt_d   = '0;
                    state_d = ST_WAIT;
                end
                ST_WAIT: begin
                    if (adc_data_vld_i) begin
`ifdef MOTOR_SAMPLE_AVG_EN
                        if (!second_q) begin
                            pos_d    = adc_data_i;
                            second_d = 1'b1;
                            state_d  = ST_REQ;
                            req_d    = 1'b1;
                        end else begin
                            pos_d    = sample_c;
                            second_d = 1'b0;
                            state_d  = ST_CALC;
                        end
`else
                        pos_d   = sample_c;
                        state_d = ST_CALC;
`endif
                    end else if (cnt_q == CNT_LAST) begin
                        tmo_d    = 1'b1;
                        state_d  = ST_IDLE;
`ifdef MOTOR_SAMPLE_AVG_EN
                        second_d = 1'b0;
`endif
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                ST_CALC: begin
                    err_d   = sat_c;
                    epos_d  = pos_q;
                    vld_d   = 1'b1;
                    state_d = ST_OUT;
                end
                ST_OUT: begin
                    if (err_rdy_i) begin
                        vld_d   = 1'b0;
                        state_d = ST_IDLE;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    vld_d   = 1'b0;
                end
            endcase
        end
        busy_d = (state_d != ST_IDLE);
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= ST_IDLE;
            trig_d_q <= 1'b0;
            cnt_q    <= '0;
            pos_q    <= '0;
            req_q    <= 1'b0;
            vld_q    <= 1'b0;
            err_q    <= '0;
            epos_q   <= '0;
            tmo_q    <= 1'b0;
            miss_q   <= '0;
            busy_q   <= 1'b0;
`ifdef MOTOR_SAMPLE_AVG_EN
            second_q <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            trig_d_q <= motor_trigger_i;
            cnt_q    <= cnt_d;
            pos_q    <= pos_d;
            req_q    <= req_d;
            vld_q    <= vld_d;
            err_q    <= err_d;
            epos_q   <= epos_d;
            tmo_q    <= tmo_d;
            miss_q   <= miss_d;
            busy_q   <= busy_d;
`ifdef MOTOR_SAMPLE_AVG_EN
            second_q <= second_d;
`endif
        end
    end

    assign adc_conv_req_o = req_q;
    assign err_vld_o      = vld_q;
    assign err_data_o     = err_q;
    assign err_pos_o      = epos_q;
    assign adc_timeout_o  = tmo_q;
    assign miss_cnt_o     = miss_q;
    assign busy_o         = busy_q;

endmodule
